// File: rtl/pseudo_spi_sram_reader_pkg.sv
// Shared encodings and widths for the pseudo-SPI SRAM reader.
// The SRAM loader and bench monitors decode the same state values.
package pseudo_spi_sram_reader_pkg;

    localparam int MEMORY_ADDR_WIDTH = 9;
    localparam int MEMORY_DATA_WIDTH = 8;
    localparam int RESERVED_DATA_LEN = 8;

    typedef enum logic [2:0] {
        SPI_IDLE = 3'b000,
        SPI_ADDR = 3'b001,
        SPI_READ = 3'b011,
        SPI_SOUT = 3'b010,
        SPI_LOOP = 3'b110,
        SPI_RDY  = 3'b100,
        SPI_DONE = 3'b101
    } spi_state_t;

endpackage

// File: rtl/pseudo_spi_sram_reader_shift_reg8.sv
// Byte shifter for the serial link: parallel load, shift right, bit 0 is the serial output.
module pseudo_spi_sram_reader_shift_reg8
    import pseudo_spi_sram_reader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         shift,
    input  logic [MEMORY_DATA_WIDTH-1:0] din,
    output logic                         sout
);

    logic [MEMORY_DATA_WIDTH-1:0] data;

    // Clear wins so an aborted byte never leaks onto the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= {1'b0, data[MEMORY_DATA_WIDTH-1:1]};
        end
    end

    assign sout = data[0];

endmodule

// File: rtl/pseudo_spi_sram_reader.sv
// Reads DATA_LEN bytes downward from ADDR_BGN-1 out of the shared SRAM and
// shifts each one out LSB first over the SCLK1/SCLK2/LAT pseudo-SPI link.
module pseudo_spi_sram_reader
    import pseudo_spi_sram_reader_pkg::*;
(
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic [MEMORY_DATA_WIDTH-1:0] PI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         LAT,
    output logic                         SPI_SO,
    output logic                         CEN,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic                         D_WE,
    output logic                         spi_is_done,
    output logic [2:0]                   spi_state
);

    spi_state_t                   state;
    logic [MEMORY_ADDR_WIDTH-1:0] addr;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_dec;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_first;
    logic [RESERVED_DATA_LEN-1:0] byte_cnt;
    logic [RESERVED_DATA_LEN-1:0] byte_cnt_inc;
    logic [RESERVED_DATA_LEN-1:0] len;
    logic [2:0]                   bit_cnt;
    logic                         abort;

    assign addr_dec     = addr - 9'd1;
    assign addr_first   = ADDR_BGN - 9'd1;
    assign byte_cnt_inc = byte_cnt + 8'd1;
    assign abort        = (state != SPI_IDLE) && !BGN;

    // A is loaded on the edge entering ADDR so it is stable while CEN is low.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SPI_IDLE;
            A        <= '0;
            addr     <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            len      <= '0;
        end else if (abort) begin
            state    <= SPI_IDLE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                SPI_IDLE: begin
                    if (BGN) begin
                        addr     <= addr_first;
                        A        <= addr_first;
                        byte_cnt <= '0;
                        len      <= DATA_LEN;
                        state    <= (DATA_LEN == 8'd0) ? SPI_DONE : SPI_ADDR;
                    end
                end
                SPI_ADDR: state <= SPI_READ;
                SPI_READ: begin
                    bit_cnt <= '0;
                    state   <= SPI_SOUT;
                end
                SPI_SOUT: state <= SPI_LOOP;
                SPI_LOOP: begin
                    if (bit_cnt == 3'd7) begin
                        state <= SPI_RDY;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= SPI_SOUT;
                    end
                end
                SPI_RDY: begin
                    addr     <= addr_dec;
                    byte_cnt <= byte_cnt_inc;
                    if (byte_cnt_inc == len) begin
                        state <= SPI_DONE;
                    end else begin
                        A     <= addr_dec;
                        state <= SPI_ADDR;
                    end
                end
                SPI_DONE: state <= SPI_DONE;
                default:  state <= SPI_IDLE;
            endcase
        end
    end

    pseudo_spi_sram_reader_shift_reg8 u_spi_shift_reg8 (
        .clk   (CLK),
        .rst_n (rst_n),
        .clear (abort),
        .load  (state == SPI_READ),
        .shift (state == SPI_LOOP),
        .din   (PI),
        .sout  (SPI_SO)
    );

    assign SCLK1       = (state == SPI_SOUT);
    assign SCLK2       = (state == SPI_LOOP);
    assign LAT         = (state == SPI_RDY);
    assign CEN         = (state != SPI_ADDR);
    assign spi_is_done = (state == SPI_DONE);
    assign D_WE        = 1'b1;
    assign spi_state   = state;

endmodule

// File: tb/tb_pseudo_spi_sram_reader.sv
// Directed bench for pseudo_spi_sram_reader with a 512x8 SRAM model and byte/address scoreboard.
module tb_pseudo_spi_sram_reader;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       BGN = 1'b0;
    logic [8:0] ADDR_BGN = '0;
    logic [7:0] DATA_LEN = '0;
    logic [7:0] PI = '0;
    logic       SCLK1, SCLK2, LAT, SPI_SO, CEN, D_WE, spi_is_done;
    logic [8:0] A;
    logic [2:0] spi_state;

    logic [7:0] mem [512];
    logic [7:0] exp_q [$];
    logic [8:0] exp_a_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int lat_total = 0;
    int sclk1_total = 0;

    pseudo_spi_sram_reader dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .BGN         (BGN),
        .ADDR_BGN    (ADDR_BGN),
        .DATA_LEN    (DATA_LEN),
        .PI          (PI),
        .SCLK1       (SCLK1),
        .SCLK2       (SCLK2),
        .LAT         (LAT),
        .SPI_SO      (SPI_SO),
        .CEN         (CEN),
        .A           (A),
        .D_WE        (D_WE),
        .spi_is_done (spi_is_done),
        .spi_state   (spi_state)
    );

    // ---- clock ----
    always #5 CLK = ~CLK;

    // ---- synchronous SRAM model, read-only here ----
    always @(posedge CLK) begin
        if (!CEN && D_WE) PI <= mem[A];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---- monitor: rebuilds bytes from SPI_SO in LOOP and pops the scoreboard on LAT ----
    logic [7:0] acc = '0;
    int         bits = 0;
    int         cyc_now = 0;
    int         last_lat = 0;
    bit         lat_seen = 1'b0;
    logic       prev_sclk2 = 1'b0;

    always @(negedge CLK) begin
        cyc_now++;
        if (!rst_n || spi_state == 3'b000) begin
            bits     = 0;
            acc      = '0;
            lat_seen = 1'b0;
        end
        if (rst_n) begin
            if (!CEN) begin
                if (exp_a_q.size() == 0) check("addr_unexpected", 32'(A), 32'h1ffff);
                else check("sram_addr", 32'(A), 32'(exp_a_q.pop_front()));
            end
            if (SCLK1) sclk1_total++;
            if (SCLK2) begin
                check("loop_single_cycle", 32'(prev_sclk2), 32'd0);
                acc = {SPI_SO, acc[7:1]};
                bits++;
            end
            if (LAT) begin
                lat_total++;
                check("bits_per_byte", 32'(bits), 32'd8);
                if (exp_q.size() == 0) check("byte_unexpected", 32'(acc), 32'h1ffff);
                else check("byte", 32'(acc), 32'(exp_q.pop_front()));
                if (lat_seen) check("byte_period", 32'(cyc_now - last_lat), 32'd19);
                lat_seen = 1'b1;
                last_lat = cyc_now;
                bits     = 0;
            end
        end
        prev_sclk2 = SCLK2;
    end

    // ---- driver tasks ----
    task automatic push_expected(input logic [8:0] ab, input logic [7:0] len);
        logic [8:0] a;
        a = ab;
        for (int i = 0; i < int'(len); i++) begin
            a = a - 9'd1;
            exp_a_q.push_back(a);
            exp_q.push_back(mem[a]);
        end
    endtask

    task automatic run_transfer(input logic [8:0] ab, input logic [7:0] len, input bit perturb);
        int lat0, sclk0, cyc;
        lat0  = lat_total;
        sclk0 = sclk1_total;
        push_expected(ab, len);
        @(negedge CLK);
        ADDR_BGN = ab;
        DATA_LEN = len;
        BGN      = 1'b1;
        cyc      = 0;
        while (!spi_is_done && cyc < 4000) begin
            @(negedge CLK);
            cyc++;
            if (perturb && cyc == 5) begin
                ADDR_BGN = ~ab;
                DATA_LEN = len + 8'd3;
            end
        end
        check("duration", 32'(cyc), (len == 8'd0) ? 32'd1 : 32'(1 + 19 * int'(len)));
        check("done", 32'(spi_is_done), 32'd1);
        check("lat_count", 32'(lat_total - lat0), 32'(len));
        check("sclk1_count", 32'(sclk1_total - sclk0), 32'(8 * int'(len)));
        check("byte_q_drained", 32'(exp_q.size()), 32'd0);
        check("addr_q_drained", 32'(exp_a_q.size()), 32'd0);
    endtask

    task automatic drop_bgn();
        @(negedge CLK);
        BGN = 1'b0;
        @(negedge CLK);
        check("idle_after_drop", 32'(spi_state), 32'd0);
        check("done_low_after_drop", 32'(spi_is_done), 32'd0);
    endtask

    // ---- directed sequence ----
    initial begin
        int lat0, cyc;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 32; i < 46; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[45] = 8'hAB;
        mem[44] = 8'h00;
        mem[43] = 8'hFF;

        // reset values
        #1;
        check("rst_cen", 32'(CEN), 32'd1);
        check("rst_dwe", 32'(D_WE), 32'd1);
        check("rst_state", 32'(spi_state), 32'd0);
        check("rst_done", 32'(spi_is_done), 32'd0);
        check("rst_so", 32'(SPI_SO), 32'd0);
        check("rst_a", 32'(A), 32'd0);
        check("rst_strobes", 32'({SCLK1, SCLK2, LAT}), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        // nominal block read 45..32
        run_transfer(9'd46, 8'd14, 1'b0);

        // done hold: no SRAM access, no strobes, flag stays up
        lat0 = lat_total;
        repeat (20) @(negedge CLK);
        check("done_hold", 32'(spi_is_done), 32'd1);
        check("done_hold_cen", 32'(CEN), 32'd1);
        check("done_hold_lat", 32'(lat_total - lat0), 32'd0);

        // restart repeats identically, inputs changed mid-run are ignored
        drop_bgn();
        run_transfer(9'd46, 8'd14, 1'b1);

        // empty transfer
        drop_bgn();
        run_transfer(9'd100, 8'd0, 1'b0);

        // address wrap below zero
        drop_bgn();
        run_transfer(9'd0, 8'd2, 1'b0);

        // abort during the 4th LOOP of byte 1
        drop_bgn();
        exp_a_q.push_back(9'd45);
        @(negedge CLK);
        ADDR_BGN = 9'd46;
        DATA_LEN = 8'd14;
        BGN      = 1'b1;
        cyc = 0;
        for (int n = 0; n < 4 && cyc < 200; ) begin
            @(negedge CLK);
            cyc++;
            if (SCLK2) n++;
        end
        check("abort_in_loop", 32'(spi_state), 32'b110);
        BGN = 1'b0;
        @(negedge CLK);
        check("abort_idle", 32'(spi_state), 32'd0);
        check("abort_so_cleared", 32'(SPI_SO), 32'd0);
        check("abort_addr_q", 32'(exp_a_q.size()), 32'd0);
        run_transfer(9'd46, 8'd14, 1'b0);

        // asynchronous reset mid-run
        drop_bgn();
        push_expected(9'd40, 8'd5);
        @(negedge CLK);
        ADDR_BGN = 9'd40;
        DATA_LEN = 8'd5;
        BGN      = 1'b1;
        repeat (30) @(negedge CLK);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cen", 32'(CEN), 32'd1);
        check("midrst_dwe", 32'(D_WE), 32'd1);
        check("midrst_state", 32'(spi_state), 32'd0);
        check("midrst_done", 32'(spi_is_done), 32'd0);
        check("midrst_so", 32'(SPI_SO), 32'd0);
        exp_q.delete();
        exp_a_q.delete();
        BGN = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        run_transfer(9'd40, 8'd5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
